usb_tx_arbiter: RTL

Sequencer and arbiter placed in front of the USB transmit path (`usb_tx`). It shares that single transmitter between two requesters:

- the handshake responder (ACK/NAK);
- the endpoint data path (DATA packets).

It issues one start command per packet and holds the packet size stable. It forwards byte fetches only to the data owner, enforces a minimum inter-packet gap, and recovers with an error pulse if the transmitter never reports completion.

---
 rtl/usb_tx_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - shares one USB transmitter between handshake and data requesters
module usb_tx_arbiter #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  input  logic       hs_type,
  output logic       hs_gnt,
  output logic       hs_done,
  input  logic       data_req,
  input  logic [6:0] data_size,
  output logic       data_gnt,
  output logic       data_done,
  output logic       data_get,
  output logic [1:0] tx_packet,
  output logic [6:0] tx_packet_data_size,
  input  logic       get_tx_packet,
  input  logic       tx_done,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam logic [11:0] LP_TIMEOUT  = 12'(TIMEOUT_CYCLES);
  localparam logic [7:0]  LP_GAP_LAST = 8'(GAP_CYCLES - 1);

  localparam logic [1:0] LP_PKT_NONE = 2'b00;
  localparam logic [1:0] LP_PKT_DATA = 2'b01;
  localparam logic [1:0] LP_PKT_ACK  = 2'b10;
  localparam logic [1:0] LP_PKT_NAK  = 2'b11;

  // owner encoding: 0 = handshake responder, 1 = endpoint data path
  state_t      r_state;
  logic        r_owner_data;
  logic [11:0] r_wdog;
  logic [7:0]  r_gap;
  logic [6:0]  r_size;
  logic [1:0]  r_tx_packet;
  logic        r_hs_gnt;
  logic        r_hs_done;
  logic        r_data_gnt;
  logic        r_data_done;
  logic        r_timeout_err;

  state_t      w_state_nxt;
  logic        w_owner_data_nxt;
  logic [11:0] w_wdog_nxt;
  logic [7:0]  w_gap_nxt;
  logic [6:0]  w_size_nxt;
  logic [1:0]  w_tx_packet_nxt;
  logic        w_hs_gnt_nxt;
  logic        w_hs_done_nxt;
  logic        w_data_gnt_nxt;
  logic        w_data_done_nxt;
  logic        w_timeout_err_nxt;

  // next-state and next-output decode; every output pulse is computed one cycle ahead
  always_comb begin
    w_state_nxt       = r_state;
    w_owner_data_nxt  = r_owner_data;
    w_wdog_nxt        = r_wdog;
    w_gap_nxt         = r_gap;
    w_size_nxt        = r_size;
    w_tx_packet_nxt   = LP_PKT_NONE;
    w_hs_gnt_nxt      = 1'b0;
    w_hs_done_nxt     = 1'b0;
    w_data_gnt_nxt    = 1'b0;
    w_data_done_nxt   = 1'b0;
    w_timeout_err_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (hs_req) begin
          w_owner_data_nxt = 1'b0;
          w_tx_packet_nxt  = hs_type ? LP_PKT_NAK : LP_PKT_ACK;
          w_hs_gnt_nxt     = 1'b1;
          w_state_nxt      = S_ISSUE;
        end else if (data_req) begin
          w_owner_data_nxt = 1'b1;
          w_size_nxt       = data_size;
          w_tx_packet_nxt  = LP_PKT_DATA;
          w_data_gnt_nxt   = 1'b1;
          w_state_nxt      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_wdog_nxt  = 12'd0;
        w_state_nxt = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // completion wins over a watchdog expiry on the same edge
        if (tx_done) begin
          w_hs_done_nxt   = ~r_owner_data;
          w_data_done_nxt = r_owner_data;
          w_gap_nxt       = 8'd0;
          w_state_nxt     = S_GAP;
        end else if (r_wdog == LP_TIMEOUT) begin
          w_timeout_err_nxt = 1'b1;
          w_gap_nxt         = 8'd0;
          w_state_nxt       = S_GAP;
        end else begin
          w_wdog_nxt = r_wdog + 12'd1;
        end
      end

      S_GAP: begin
        if (r_gap == LP_GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap + 8'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // state, counters, latched size and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_owner_data  <= 1'b0;
      r_wdog        <= 12'd0;
      r_gap         <= 8'd0;
      r_size        <= 7'd0;
      r_tx_packet   <= LP_PKT_NONE;
      r_hs_gnt      <= 1'b0;
      r_hs_done     <= 1'b0;
      r_data_gnt    <= 1'b0;
      r_data_done   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner_data  <= w_owner_data_nxt;
      r_wdog        <= w_wdog_nxt;
      r_gap         <= w_gap_nxt;
      r_size        <= w_size_nxt;
      r_tx_packet   <= w_tx_packet_nxt;
      r_hs_gnt      <= w_hs_gnt_nxt;
      r_hs_done     <= w_hs_done_nxt;
      r_data_gnt    <= w_data_gnt_nxt;
      r_data_done   <= w_data_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign hs_gnt              = r_hs_gnt;
  assign hs_done             = r_hs_done;
  assign data_gnt            = r_data_gnt;
  assign data_done           = r_data_done;
  assign tx_packet           = r_tx_packet;
  assign tx_packet_data_size = r_size;
  assign timeout_err         = r_timeout_err;
  assign busy                = (r_state != S_IDLE);
  // byte fetches reach the data source only while its own packet is on the wire
  assign data_get            = get_tx_packet & r_owner_data & (r_state == S_WAIT_DONE);

endmodule
